// File: rtl/biriscv_fetch_responder.sv
// Fetch-side responder: forwards aligned instruction reads to memory, answers
// privilege/range faults locally, and drops stale data across flush/invalidate.
//
// state | meaning
// RUN   | normal operation, requests accepted
// FLUSH | draining reads issued before a flush, their data is discarded
// INVAL | invalidate sweep in progress, also drains and discards in-flight data
module biriscv_fetch_responder #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          INV_CYCLES      = 64,
    parameter logic [31:0] MEM_BASE        = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE        = 32'h0001_0000,
    parameter logic [31:0] SUPV_BASE       = 32'h8000_8000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_rd_i,
    input  logic        req_flush_i,
    input  logic        req_invalidate_i,
    input  logic [31:0] req_pc_i,
    input  logic [1:0]  req_priv_i,
    output logic        req_accept_o,
    output logic        resp_valid_o,
    output logic [63:0] resp_inst_o,
    output logic        resp_error_o,
    output logic        resp_page_fault_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_accept_i,
    input  logic        mem_valid_i,
    input  logic [63:0] mem_data_i,
    input  logic        mem_error_i
);

    localparam int          SW       = $clog2(INV_CYCLES + 1);
    localparam logic [SW-1:0] INV_LOAD = SW'(INV_CYCLES);
    localparam logic [1:0]  MAX_Q    = 2'(MAX_OUTSTANDING);
    localparam logic [32:0] MEM_END  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    typedef enum logic [1:0] {RUN, FLUSH, INVAL} state_t;

    state_t        state_q, state_d;
    logic [1:0]    out_q, out_d;
    logic [1:0]    drop_q, drop_d;
    logic [SW-1:0] sweep_q, sweep_d;
    logic          local_q, local_d;
    logic          resp_valid_q, resp_valid_d;
    logic [63:0]   resp_inst_q, resp_inst_d;
    logic          resp_error_q, resp_error_d;
    logic          resp_pf_q, resp_pf_d;

    logic page_fault_w, range_fault_w, normal_w;
    logic mem_take_w, mem_ret_w, fault_ok_w, fault_take_w, mem_resp_w;

    assign page_fault_w  = (req_priv_i == 2'd0) && (req_pc_i >= SUPV_BASE);
    assign range_fault_w = !page_fault_w &&
                           ((req_pc_i < MEM_BASE) || ({1'b0, req_pc_i} >= MEM_END));
    assign normal_w      = !page_fault_w && !range_fault_w;
    assign mem_addr_o    = {req_pc_i[31:3], 3'b000};

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        drop_d       = drop_q;
        sweep_d      = sweep_q;
        local_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_inst_d  = '0;
        resp_error_d = 1'b0;
        resp_pf_d    = 1'b0;

        mem_rd_o     = rst_ni && req_rd_i && (state_q == RUN) && normal_w &&
                       (out_q < MAX_Q) && !req_flush_i && !req_invalidate_i;
        mem_take_w   = mem_rd_o && mem_accept_i;
        // A local fault answer must not collide with, or overtake, memory data.
        fault_ok_w   = rst_ni && (state_q == RUN) && (out_q == 2'd0) && !mem_valid_i &&
                       !local_q && !req_flush_i && !req_invalidate_i;
        req_accept_o = normal_w ? mem_take_w : fault_ok_w;
        fault_take_w = req_rd_i && fault_ok_w && !normal_w;
        mem_ret_w    = mem_valid_i && (out_q != 2'd0);
        mem_resp_w   = mem_ret_w && (state_q == RUN) && (drop_q == 2'd0);

        case ({mem_take_w, mem_ret_w})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
        endcase

        if (mem_ret_w && (state_q != RUN) && (drop_q != 2'd0))
            drop_d = drop_q - 2'd1;

        if (mem_resp_w || fault_take_w) begin
            resp_valid_d = 1'b1;
            resp_inst_d  = mem_resp_w ? mem_data_i : 64'd0;
            resp_error_d = mem_resp_w ? mem_error_i : range_fault_w;
            resp_pf_d    = fault_take_w && page_fault_w;
        end
        local_d = fault_take_w;

        case (state_q)
            FLUSH: begin
                if (out_d == 2'd0)
                    state_d = RUN;
            end
            INVAL: begin
                if (sweep_q != '0)
                    sweep_d = sweep_q - 1'b1;
                if ((sweep_d == '0) && (out_d == 2'd0))
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (req_invalidate_i) begin
            state_d = INVAL;
            sweep_d = INV_LOAD;
            drop_d  = out_d;
        end else if (req_flush_i) begin
            drop_d = out_d;
            if (state_q != INVAL)
                state_d = FLUSH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            out_q        <= 2'd0;
            drop_q       <= 2'd0;
            sweep_q      <= '0;
            local_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= 64'd0;
            resp_error_q <= 1'b0;
            resp_pf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            sweep_q      <= sweep_d;
            local_q      <= local_d;
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            resp_error_q <= resp_error_d;
            resp_pf_q    <= resp_pf_d;
        end
    end

    assign resp_valid_o      = resp_valid_q;
    assign resp_inst_o       = resp_inst_q;
    assign resp_error_o      = resp_error_q;
    assign resp_page_fault_o = resp_pf_q;

endmodule
